// File: rtl/wishbone_slv_stream_fifo.sv
// Wishbone register slave feeding a 32-bit stream FIFO (DATA/STATUS/CTRL/IRQ).
// Define WB_SLV_STREAM_IRQ_EN to add the level-threshold interrupt and irq_o port.
module wishbone_slv_stream_fifo #(
    parameter int unsigned FIFO_AW       = 4,
    parameter logic [4:0]  RST_THRESHOLD = 5'd4
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:0] wbs_adr_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        st_valid_o,
    output logic [31:0] st_data_o,
    input  logic        st_ready_i
`ifdef WB_SLV_STREAM_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_IRQ    = 2'd3
    } reg_sel_t;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               enable;
    logic [4:0]         thresh;
    logic               overflow;

    reg_sel_t           reg_addr;
    logic               access;
    logic               wr_access;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push_req;
    logic               push;
    logic               flush;
    logic               ovf_clear;
    logic [31:0]        status_word;
    logic [31:0]        read_mux;
    logic               unused_bits;

    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:2]};

    // A new access is recognised only while ack is low, forcing a gap between acks.
    assign access    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr_access = access & wbs_we_i;
    assign reg_addr  = reg_sel_t'(wbs_adr_i[3:2]);

    assign empty = (level == '0);
    // Level never exceeds DEPTH, so its top bit alone marks full.
    assign full  = level[FIFO_AW];

    assign st_valid_o = enable & ~empty;
    assign st_data_o  = mem[rd_ptr];
    assign pop        = st_valid_o & st_ready_i;

    assign push_req  = wr_access & (reg_addr == REG_DATA);
    assign push      = push_req & (~full | pop);
    assign flush     = wr_access & (reg_addr == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[1];
    assign ovf_clear = wr_access & (reg_addr == REG_STATUS) & wbs_sel_i[1] & wbs_dat_i[10];

`ifdef WB_SLV_STREAM_IRQ_EN
    logic ie;
    logic pending;

    assign pending = (32'(level) <= 32'(thresh));

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            ie    <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            irq_o <= ie & pending;
            if (wr_access && reg_addr == REG_IRQ && wbs_sel_i[0]) begin
                ie <= wbs_dat_i[0];
            end
        end
    end
`endif

    always_comb begin
        status_word              = '0;
        status_word[FIFO_AW:0]   = level;
        status_word[8]           = empty;
        status_word[9]           = full;
        status_word[10]          = overflow;
    end

    always_comb begin
        read_mux = '0;
        case (reg_addr)
            REG_DATA:   read_mux = '0;
            REG_STATUS: read_mux = status_word;
            REG_CTRL: begin
                read_mux[0]    = enable;
                read_mux[12:8] = thresh;
            end
            REG_IRQ: begin
`ifdef WB_SLV_STREAM_IRQ_EN
                read_mux[0] = ie;
                read_mux[1] = pending;
`else
                read_mux = '0;
`endif
            end
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wbs_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            enable    <= 1'b0;
            thresh    <= RST_THRESHOLD;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= (access && !wbs_we_i) ? read_mux : '0;

            // Flush overrides any pop in the same cycle; a push cannot coincide with it.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    level <= level + 1'b1;
                end else if (pop && !push) begin
                    level <= level - 1'b1;
                end
            end

            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end

            if (wr_access && reg_addr == REG_CTRL) begin
                if (wbs_sel_i[0]) begin
                    enable <= wbs_dat_i[0];
                end
                if (wbs_sel_i[1]) begin
                    thresh <= wbs_dat_i[12:8];
                end
            end
        end
    end

endmodule
